// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared state encoding and line constants for the FIFO-fed UART transmitter
package fifo_uart_pkg;
  typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, PARITY, STOP} state_t;
  localparam int DATA_BITS = 8;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL = 1'b0;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: counts CLKS_PER_BIT cycles and flags the last cycle of each bit
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  assign bit_end = cnt == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk)
    if (rst || clear || bit_end) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the FIFO read port and serialises them as UART frames
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic             buf_empty,
  input  logic [7:0]       buf_out,
  output logic             rd_en,
  output logic             tx,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] byte_count
);
  state_t state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0] idx;
  logic parity;
  logic bit_end;
  logic clear;
  // holding the counter clear until START means every bit period starts from zero
  assign clear = state inside {IDLE, REQ, LOAD};
  assign busy = state != IDLE;
  assign frame_done = state == STOP && bit_end;
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .bit_end(bit_end)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      tx <= IDLE_LEVEL;
      rd_en <= 1'b0;
      shift <= '0;
      idx <= '0;
      parity <= 1'b0;
      byte_count <= '0;
    end else begin
      rd_en <= 1'b0;
      case (state)
        IDLE: if (tx_en && !buf_empty) begin
          state <= REQ;
          rd_en <= 1'b1;
        end
        REQ: state <= LOAD;
        LOAD: begin
          shift <= buf_out;
          parity <= ^buf_out;
          tx <= START_LEVEL;
          state <= START;
        end
        START: if (bit_end) begin
          tx <= shift[0];
          idx <= '0;
          state <= DATA;
        end
        DATA: if (bit_end) begin
          shift <= shift >> 1;
          idx <= idx + 1'b1;
          if (idx == 3'(DATA_BITS - 1)) begin
            tx <= PARITY_EN ? parity : IDLE_LEVEL;
            state <= PARITY_EN ? PARITY : STOP;
          end else tx <= shift[1];
        end
        PARITY: if (bit_end) begin
          tx <= IDLE_LEVEL;
          state <= STOP;
        end
        STOP: if (bit_end) begin
          byte_count <= byte_count + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed checks of framing, handshake, flow control, reset and counter wrap
module tb_fifo_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_en0 = 1'b1;
  logic tx_en1 = 1'b0;
  logic hold_empty = 1'b0;
  logic buf_empty;
  logic [7:0] buf_out = 8'h00;
  logic rd_en0, tx0, busy0, fd0;
  logic rd_en1, tx1, busy1, fd1;
  logic [15:0] byte_count0;
  logic [1:0] byte_count1;
  logic [7:0] mem [0:31];
  int rp = 0;
  int wp = 0;
  int rd_cnt0 = 0;
  int rd_cnt1 = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign buf_empty = hold_empty || (rp == wp);

  always @(posedge clk) begin
    if (rd_en0 || rd_en1) begin
      buf_out <= mem[rp];
      rp <= rp + 1;
    end
    if (rd_en0) rd_cnt0 <= rd_cnt0 + 1;
    if (rd_en1) rd_cnt1 <= rd_cnt1 + 1;
  end

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .tx_en(tx_en0), .buf_empty(buf_empty), .buf_out(buf_out),
    .rd_en(rd_en0), .tx(tx0), .busy(busy0), .frame_done(fd0), .byte_count(byte_count0)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .tx_en(tx_en1), .buf_empty(buf_empty), .buf_out(buf_out),
    .rd_en(rd_en1), .tx(tx1), .busy(busy1), .frame_done(fd1), .byte_count(byte_count1)
  );

  function automatic logic txs(input bit s);
    return s ? tx1 : tx0;
  endfunction
  function automatic logic rds(input bit s);
    return s ? rd_en1 : rd_en0;
  endfunction
  function automatic logic bsy(input bit s);
    return s ? busy1 : busy0;
  endfunction
  function automatic logic fds(input bit s);
    return s ? fd1 : fd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp] = b;
    wp++;
  endtask

  // called in the IDLE cycle whose closing edge starts the frame; returns in LOAD
  task automatic start_frame(input bit s);
    tick;
    chk("rd_pulse", 32'(rds(s)), 1);
    chk("req_tx", 32'(txs(s)), 1);
    chk("req_busy", 32'(bsy(s)), 1);
    tick;
    chk("rd_single", 32'(rds(s)), 0);
    chk("load_tx", 32'(txs(s)), 1);
  endtask

  // called in LOAD; returns on the last stop-bit cycle
  task automatic expect_frame(input bit s, input logic [7:0] b, input bit pen);
    logic [10:0] bits;
    int n;
    n = pen ? 11 : 10;
    bits = pen ? {1'b1, ^b, b, 1'b0} : {2'b11, b, 1'b0};
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 4; j++) begin
        tick;
        chk($sformatf("tx_b%0h_bit%0d", b, i), 32'(txs(s)), 32'(bits[i]));
        if (i == n - 1 && j >= 2) chk("frame_done", 32'(fds(s)), (j == 3) ? 1 : 0);
      end
  endtask

  task automatic idle_gap(input bit s);
    tick;
    chk("gap_tx", 32'(txs(s)), 1);
    chk("gap_busy", 32'(bsy(s)), 0);
    chk("gap_rd", 32'(rds(s)), 0);
  endtask

  initial begin
    push(8'hA5);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_tx", 32'(tx0), 1);
      chk("rst_rd", 32'(rd_en0), 0);
      chk("rst_busy", 32'(busy0), 0);
      chk("rst_cnt", 32'(byte_count0), 0);
    end
    rst = 1'b0;
    start_frame(0);
    expect_frame(0, 8'hA5, 0);
    tick;
    chk("cnt_after_a5", 32'(byte_count0), 1);
    chk("busy_after_a5", 32'(busy0), 0);
    chk("pops_after_a5", 32'(rd_cnt0), 1);
    push(8'h01);
    push(8'h80);
    start_frame(0);
    expect_frame(0, 8'h01, 0);
    idle_gap(0);
    start_frame(0);
    expect_frame(0, 8'h80, 0);
    tick;
    chk("cnt_b2b", 32'(byte_count0), 3);
    chk("pops_b2b", 32'(rd_cnt0), 3);
    hold_empty = 1'b1;
    push(8'h3C);
    for (int i = 0; i < 50; i++) begin
      tick;
      chk("empty_rd", 32'(rd_en0), 0);
      chk("empty_tx", 32'(tx0), 1);
    end
    hold_empty = 1'b0;
    tx_en0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("txen0_rd", 32'(rd_en0), 0);
      chk("txen0_busy", 32'(busy0), 0);
    end
    tx_en0 = 1'b1;
    start_frame(0);
    tx_en0 = 1'b0;
    push(8'hFF);
    expect_frame(0, 8'h3C, 0);
    tick;
    chk("cnt_txen_drop", 32'(byte_count0), 4);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("stay_idle_busy", 32'(busy0), 0);
      chk("stay_idle_rd", 32'(rd_en0), 0);
    end
    tx_en0 = 1'b1;
    start_frame(0);
    tx_en0 = 1'b0;
    for (int i = 0; i < 18; i++) tick;
    chk("mid_data_tx", 32'(tx0), 1);
    chk("mid_data_busy", 32'(busy0), 1);
    rst = 1'b1;
    tick;
    chk("abort_tx", 32'(tx0), 1);
    chk("abort_busy", 32'(busy0), 0);
    chk("abort_cnt", 32'(byte_count0), 0);
    chk("abort_fd", 32'(fd0), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("post_abort_busy", 32'(busy0), 0);
      chk("post_abort_tx", 32'(tx0), 1);
      chk("post_abort_rd", 32'(rd_en0), 0);
    end
    push(8'h07);
    push(8'h03);
    push(8'h00);
    push(8'hFF);
    tx_en1 = 1'b1;
    start_frame(1);
    expect_frame(1, 8'h07, 1);
    idle_gap(1);
    start_frame(1);
    expect_frame(1, 8'h03, 1);
    idle_gap(1);
    start_frame(1);
    expect_frame(1, 8'h00, 1);
    idle_gap(1);
    chk("par_cnt3", 32'(byte_count1), 3);
    start_frame(1);
    expect_frame(1, 8'hFF, 1);
    tick;
    chk("par_cnt_wrap", 32'(byte_count1), 0);
    chk("par_pops", 32'(rd_cnt1), 4);
    chk("par_busy", 32'(busy1), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer for the dual-clock byte FIFO, running in the FIFO's read clock domain.
- Pops one byte at a time using the FIFO's read handshake (rd_en pulse, registered data one cycle later).
- Serialises each byte as an 8-bit UART frame: start bit, 8 data bits LSB first, optional even parity, 1 stop bit.
- Provides frame status and a running byte count for the host.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal values >= 2.
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits; 0 means no parity bit.
- CNT_W, 16, width of the sent-byte counter.

Ports:
- clk  input  1  read-domain clock (the same clock as the FIFO clk_rd).
- rst  input  1  synchronous, active-high reset.
- tx_en  input  1  allows a new frame to start; sampled only in IDLE.
- buf_empty  input  1  FIFO empty flag.
- buf_out  input  8  FIFO read data; valid the cycle after the rd_en cycle.
- rd_en  output  1  registered FIFO pop request; one-cycle pulse per byte.
- tx  output  1  serial line; idles high.
- busy  output  1  high whenever state != IDLE.
- frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.
- byte_count  output  CNT_W  number of frames completed; wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; tx=1; rd_en=0; busy=0; frame_done=0; byte_count=0.
  - Shift register, baud counter and bit index are all cleared.
  - Reset mid-frame aborts the frame: tx returns high on the next edge, any byte already popped is dropped, and byte_count is cleared.
- States: IDLE, REQ, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If tx_en=1 and buf_empty=0 at an edge, go to REQ and set rd_en=1.
  - Otherwise stay in IDLE.
- REQ:
  - rd_en=1 for exactly this one cycle; the FIFO latches buf_out at the end of this cycle.
  - Go to LOAD. rd_en is never high for two consecutive cycles.
- LOAD:
  - Capture buf_out into the shift register.
  - Compute parity = XOR of the 8 data bits.
  - Go to START; tx=0 from the next cycle.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit.
  - After bit 7, go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: tx = parity for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - frame_done=1 and byte_count += 1 on the final cycle.
  - Then go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and resets on every state entry.
  - A bit ends when the count reaches CLKS_PER_BIT-1.
- Latency:
  - From the edge where IDLE samples tx_en=1 and buf_empty=0: rd_en is high on cycle 1, LOAD is cycle 2, and tx falls at cycle 3.
  - Frame length = (10 + PARITY_EN) * CLKS_PER_BIT cycles.
  - Minimum idle gap between back-to-back frames is 3 cycles (IDLE, REQ, LOAD) at tx=1.
- Boundary conditions:
  - buf_empty=1 in IDLE: no pop; rd_en never asserts while the FIFO is empty.
  - buf_empty and tx_en are ignored outside IDLE.
  - Deasserting tx_en mid-frame does not abort; the current frame completes, then the block stays in IDLE.
  - byte_count wraps from 2^CNT_W-1 to 0 without a flag.

Decomposition:
- Shared package fifo_uart_pkg holds:
  - the state enum (IDLE..STOP, 3-bit encoding);
  - the constant DATA_BITS=8;
  - the line-level constants IDLE_LEVEL=1 and START_LEVEL=0.
- Sub-module uart_baud_tick:
  - Parameter CLKS_PER_BIT; inputs clk, rst, clear; output bit_end (one-cycle pulse).
  - Its counter width is $clog2(CLKS_PER_BIT).

Test Plan:
- Reset: hold rst=1 for 3 cycles with buf_empty=0 and tx_en=1 -> tx=1, rd_en=0, busy=0, byte_count=0 throughout reset.
- Single byte 0xA5, CLKS_PER_BIT=4, PARITY_EN=0:
  - rd_en pulses once at cycle 1; tx falls at cycle 3.
  - Line sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - frame_done at cycle 42; byte_count=1.
- Parity, PARITY_EN=1:
  - Byte 0x07 -> parity bit 1.
  - Byte 0x03 -> parity bit 0.
  - Frame length 44 cycles each.
- Back-to-back bytes 0x01, 0x80 with buf_empty held 0:
  - Exactly 2 rd_en pulses, 3 idle-high cycles between the two frames.
  - byte_count=2.
- Flow control:
  - buf_empty=1 for 50 cycles -> rd_en=0, tx=1.
  - tx_en=0 with buf_empty=0 -> no pop.
  - Dropping tx_en mid-frame -> the frame completes.
- Reset mid-DATA (bit 3 of 0xFF) -> next edge: tx=1, state IDLE, byte_count=0, no frame_done pulse.
